// File: rtl/regfile_wb_scoreboard_if.sv
// rtl/regfile_wb_scoreboard_if.sv - issue/writeback/operand bundle for the register-file scoreboard
interface regfile_wb_scoreboard_if #(
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 2**ADDR_W
);
   logic                Issue_Valid_i;
   logic [ADDR_W-1:0]   Issue_Register_i;
   logic                Issue_Ready_o;
   logic                WB_Valid_i;
   logic [ADDR_W-1:0]   Write_Register_i;
   logic [ADDR_W-1:0]   Read_Register_A_i;
   logic [ADDR_W-1:0]   Read_Register_B_i;
   logic                Hazard_A_o;
   logic                Hazard_B_o;
   logic [NUM_REGS-1:0] CP_o;
   logic [NUM_REGS-1:0] Pending_o;
   logic [ADDR_W:0]     Pending_Count_o;
   logic                Err_o;

   modport master (
      output Issue_Valid_i, Issue_Register_i, WB_Valid_i, Write_Register_i,
             Read_Register_A_i, Read_Register_B_i,
      input  Issue_Ready_o, Hazard_A_o, Hazard_B_o, CP_o, Pending_o,
             Pending_Count_o, Err_o
   );

   modport slave (
      input  Issue_Valid_i, Issue_Register_i, WB_Valid_i, Write_Register_i,
             Read_Register_A_i, Read_Register_B_i,
      output Issue_Ready_o, Hazard_A_o, Hazard_B_o, CP_o, Pending_o,
             Pending_Count_o, Err_o
   );
endinterface

// File: rtl/regfile_wb_scoreboard.sv
// rtl/regfile_wb_scoreboard.sv - write-enable decoder with pending-write scoreboard and RAW/WAW hazard flags
module regfile_wb_scoreboard #(
   parameter int ADDR_W           = 5,
   parameter int NUM_REGS         = 2**ADDR_W,
   parameter bit ZERO_REG_PROTECT = 1'b1
) (
   input logic                    clk,
   input logic                    reset,
   regfile_wb_scoreboard_if.slave bus
);
   localparam logic [NUM_REGS-1:0] ONE       = NUM_REGS'(1);
   localparam logic [NUM_REGS-1:0] KEEP_MASK = ZERO_REG_PROTECT ? ~ONE : {NUM_REGS{1'b1}};

   logic [NUM_REGS-1:0] pending_q, pending_d;
   logic [NUM_REGS-1:0] cp_q, cp_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic                err_q, err_d;
   logic [NUM_REGS-1:0] wbclr;
   logic [NUM_REGS-1:0] iss_set;
   logic                issue_ready;
   logic                wb_to_zero;

   always_comb begin
      wbclr       = bus.WB_Valid_i ? (ONE << bus.Write_Register_i) : '0;
      issue_ready = ~(pending_q[bus.Issue_Register_i] & ~wbclr[bus.Issue_Register_i]);
      iss_set     = (bus.Issue_Valid_i && issue_ready) ? (ONE << bus.Issue_Register_i) : '0;
      // Set wins over clear when issue and writeback hit the same register.
      pending_d   = ((pending_q & ~wbclr) | iss_set) & KEEP_MASK;
      cp_d        = wbclr & KEEP_MASK;
      count_d     = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         count_d = count_d + {{ADDR_W{1'b0}}, pending_d[r]};
      end
      wb_to_zero  = ZERO_REG_PROTECT && (bus.Write_Register_i == '0);
      err_d       = err_q | (bus.WB_Valid_i & ~pending_q[bus.Write_Register_i] & ~wb_to_zero);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= '0;
         cp_q      <= '0;
         count_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         cp_q      <= cp_d;
         count_q   <= count_d;
         err_q     <= err_d;
      end
   end

   // A register being written this cycle is forwarded, so it does not stall reads.
   assign bus.Hazard_A_o      = pending_q[bus.Read_Register_A_i] & ~wbclr[bus.Read_Register_A_i];
   assign bus.Hazard_B_o      = pending_q[bus.Read_Register_B_i] & ~wbclr[bus.Read_Register_B_i];
   assign bus.Issue_Ready_o   = issue_ready;
   assign bus.CP_o            = cp_q;
   assign bus.Pending_o       = pending_q;
   assign bus.Pending_Count_o = count_q;
   assign bus.Err_o           = err_q;
endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// tb/tb_regfile_wb_scoreboard.sv - directed self-checking bench for regfile_wb_scoreboard
module tb_regfile_wb_scoreboard;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   regfile_wb_scoreboard_if #(.ADDR_W(5)) b0 ();
   regfile_wb_scoreboard_if #(.ADDR_W(3)) b1 ();

   regfile_wb_scoreboard #(.ADDR_W(5), .ZERO_REG_PROTECT(1'b1)) u0 (
      .clk(clk), .reset(reset), .bus(b0.slave)
   );
   regfile_wb_scoreboard #(.ADDR_W(3), .ZERO_REG_PROTECT(1'b0)) u1 (
      .clk(clk), .reset(reset), .bus(b1.slave)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      b0.Issue_Valid_i = 1'b0; b0.Issue_Register_i = '0; b0.WB_Valid_i = 1'b0;
      b0.Write_Register_i = '0; b0.Read_Register_A_i = '0; b0.Read_Register_B_i = '0;
      b1.Issue_Valid_i = 1'b0; b1.Issue_Register_i = '0; b1.WB_Valid_i = 1'b0;
      b1.Write_Register_i = '0; b1.Read_Register_A_i = '0; b1.Read_Register_B_i = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      tick();
      tick();
      reset = 1'b0;
      #1;
      checks++; if (b0.CP_o !== 32'h0) begin errors++; $display("FAIL rst_cp got %h exp %h", b0.CP_o, 32'h0); end
      checks++; if (b0.Pending_o !== 32'h0) begin errors++; $display("FAIL rst_pend got %h exp %h", b0.Pending_o, 32'h0); end
      checks++; if (b0.Pending_Count_o !== 6'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", b0.Pending_Count_o); end
      checks++; if (b0.Err_o !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", b0.Err_o); end
      checks++; if (b0.Issue_Ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", b0.Issue_Ready_o); end
      checks++; if (b1.Pending_o !== 8'h0) begin errors++; $display("FAIL rst_pend1 got %h exp 00", b1.Pending_o); end
      tick();
   endtask

   task automatic test_issue_wb();
      b0.Issue_Valid_i = 1'b1; b0.Issue_Register_i = 5'd5; b0.Read_Register_A_i = 5'd5;
      #1;
      checks++; if (b0.Issue_Ready_o !== 1'b1) begin errors++; $display("FAIL iw_ready got %b exp 1", b0.Issue_Ready_o); end
      checks++; if (b0.Hazard_A_o !== 1'b0) begin errors++; $display("FAIL iw_haz_c1 got %b exp 0", b0.Hazard_A_o); end
      tick();
      b0.Issue_Valid_i = 1'b0;
      #1;
      checks++; if (b0.Pending_o !== 32'h20) begin errors++; $display("FAIL iw_pend_c2 got %h exp %h", b0.Pending_o, 32'h20); end
      checks++; if (b0.Pending_Count_o !== 6'd1) begin errors++; $display("FAIL iw_cnt_c2 got %0d exp 1", b0.Pending_Count_o); end
      checks++; if (b0.Hazard_A_o !== 1'b1) begin errors++; $display("FAIL iw_haz_c2 got %b exp 1", b0.Hazard_A_o); end
      tick();
      #1;
      checks++; if (b0.Hazard_A_o !== 1'b1) begin errors++; $display("FAIL iw_haz_c3 got %b exp 1", b0.Hazard_A_o); end
      checks++; if (b0.CP_o !== 32'h0) begin errors++; $display("FAIL iw_cp_c3 got %h exp 0", b0.CP_o); end
      tick();
      b0.WB_Valid_i = 1'b1; b0.Write_Register_i = 5'd5;
      #1;
      checks++; if (b0.Hazard_A_o !== 1'b0) begin errors++; $display("FAIL iw_bypass got %b exp 0", b0.Hazard_A_o); end
      checks++; if (b0.Pending_o !== 32'h20) begin errors++; $display("FAIL iw_pend_c4 got %h exp %h", b0.Pending_o, 32'h20); end
      tick();
      b0.WB_Valid_i = 1'b0;
      #1;
      checks++; if (b0.CP_o !== 32'h20) begin errors++; $display("FAIL iw_cp_c5 got %h exp %h", b0.CP_o, 32'h20); end
      checks++; if (b0.Pending_o !== 32'h0) begin errors++; $display("FAIL iw_pend_c5 got %h exp 0", b0.Pending_o); end
      checks++; if (b0.Pending_Count_o !== 6'd0) begin errors++; $display("FAIL iw_cnt_c5 got %0d exp 0", b0.Pending_Count_o); end
      tick();
      #1;
      checks++; if (b0.CP_o !== 32'h0) begin errors++; $display("FAIL iw_cp_c6 got %h exp 0", b0.CP_o); end
      checks++; if (b0.Err_o !== 1'b0) begin errors++; $display("FAIL iw_err got %b exp 0", b0.Err_o); end
      tick();
   endtask

   task automatic test_waw();
      idle();
      b0.Issue_Valid_i = 1'b1; b0.Issue_Register_i = 5'd7;
      #1;
      checks++; if (b0.Issue_Ready_o !== 1'b1) begin errors++; $display("FAIL waw_ready1 got %b exp 1", b0.Issue_Ready_o); end
      tick();
      #1;
      checks++; if (b0.Issue_Ready_o !== 1'b0) begin errors++; $display("FAIL waw_stall got %b exp 0", b0.Issue_Ready_o); end
      tick();
      b0.WB_Valid_i = 1'b1; b0.Write_Register_i = 5'd7;
      #1;
      checks++; if (b0.Pending_o !== 32'h80) begin errors++; $display("FAIL waw_pend_hold got %h exp %h", b0.Pending_o, 32'h80); end
      checks++; if (b0.Pending_Count_o !== 6'd1) begin errors++; $display("FAIL waw_cnt_hold got %0d exp 1", b0.Pending_Count_o); end
      checks++; if (b0.Issue_Ready_o !== 1'b1) begin errors++; $display("FAIL waw_ready_wb got %b exp 1", b0.Issue_Ready_o); end
      tick();
      b0.Issue_Valid_i = 1'b0;
      #1;
      checks++; if (b0.Pending_o !== 32'h80) begin errors++; $display("FAIL waw_setwins got %h exp %h", b0.Pending_o, 32'h80); end
      checks++; if (b0.CP_o !== 32'h80) begin errors++; $display("FAIL waw_cp got %h exp %h", b0.CP_o, 32'h80); end
      checks++; if (b0.Err_o !== 1'b0) begin errors++; $display("FAIL waw_err got %b exp 0", b0.Err_o); end
      tick();
      b0.WB_Valid_i = 1'b0;
      #1;
      checks++; if (b0.Pending_o !== 32'h0) begin errors++; $display("FAIL waw_clear got %h exp 0", b0.Pending_o); end
      tick();
   endtask

   task automatic test_wb_sweep();
      logic [31:0] exp_cp;
      idle();
      for (int i = 0; i < 32; i++) begin
         b0.WB_Valid_i = 1'b1; b0.Write_Register_i = 5'(i);
         tick();
         exp_cp = 32'h1 << i;
         if (i == 0) exp_cp = 32'h0;
         checks++; if (b0.CP_o !== exp_cp) begin errors++; $display("FAIL sweep_cp[%0d] got %h exp %h", i, b0.CP_o, exp_cp); end
         checks++; if (b0.Err_o !== (i >= 1)) begin errors++; $display("FAIL sweep_err[%0d] got %b exp %b", i, b0.Err_o, (i >= 1)); end
      end
      b0.WB_Valid_i = 1'b0;
      tick();
      checks++; if (b0.CP_o !== 32'h0) begin errors++; $display("FAIL sweep_cp_end got %h exp 0", b0.CP_o); end
      checks++; if (b0.Pending_o !== 32'h0) begin errors++; $display("FAIL sweep_pend got %h exp 0", b0.Pending_o); end
   endtask

   task automatic test_reset_mid();
      idle();
      b0.Issue_Valid_i = 1'b1; b0.Issue_Register_i = 5'd1;
      tick();
      b0.Issue_Register_i = 5'd2;
      tick();
      b0.Issue_Register_i = 5'd3;
      tick();
      b0.Issue_Valid_i = 1'b0;
      #1;
      checks++; if (b0.Pending_o !== 32'h0E) begin errors++; $display("FAIL rm_pend got %h exp %h", b0.Pending_o, 32'h0E); end
      checks++; if (b0.Pending_Count_o !== 6'd3) begin errors++; $display("FAIL rm_cnt got %0d exp 3", b0.Pending_Count_o); end
      checks++; if (b0.Err_o !== 1'b1) begin errors++; $display("FAIL rm_err_sticky got %b exp 1", b0.Err_o); end
      reset = 1'b1; b0.WB_Valid_i = 1'b1; b0.Write_Register_i = 5'd2;
      tick();
      reset = 1'b0; b0.WB_Valid_i = 1'b0;
      #1;
      checks++; if (b0.CP_o !== 32'h0) begin errors++; $display("FAIL rm_cp got %h exp 0", b0.CP_o); end
      checks++; if (b0.Pending_o !== 32'h0) begin errors++; $display("FAIL rm_pend0 got %h exp 0", b0.Pending_o); end
      checks++; if (b0.Pending_Count_o !== 6'd0) begin errors++; $display("FAIL rm_cnt0 got %0d exp 0", b0.Pending_Count_o); end
      checks++; if (b0.Err_o !== 1'b0) begin errors++; $display("FAIL rm_err0 got %b exp 0", b0.Err_o); end
      tick();
      checks++; if (b0.CP_o !== 32'h0) begin errors++; $display("FAIL rm_cp_late got %h exp 0", b0.CP_o); end
   endtask

   task automatic test_zero_protect();
      idle();
      b0.Issue_Valid_i = 1'b1; b0.Issue_Register_i = 5'd0; b0.Read_Register_A_i = 5'd0;
      tick();
      #1;
      checks++; if (b0.Issue_Ready_o !== 1'b1) begin errors++; $display("FAIL z_ready got %b exp 1", b0.Issue_Ready_o); end
      checks++; if (b0.Pending_o !== 32'h0) begin errors++; $display("FAIL z_pend got %h exp 0", b0.Pending_o); end
      checks++; if (b0.Hazard_A_o !== 1'b0) begin errors++; $display("FAIL z_haz got %b exp 0", b0.Hazard_A_o); end
      b0.Issue_Valid_i = 1'b0; b0.WB_Valid_i = 1'b1; b0.Write_Register_i = 5'd0;
      tick();
      b0.WB_Valid_i = 1'b0;
      #1;
      checks++; if (b0.CP_o !== 32'h0) begin errors++; $display("FAIL z_cp got %h exp 0", b0.CP_o); end
      checks++; if (b0.Err_o !== 1'b0) begin errors++; $display("FAIL z_err got %b exp 0", b0.Err_o); end
      tick();
   endtask

   task automatic test_small_unprotected();
      idle();
      b1.Issue_Valid_i = 1'b1; b1.Issue_Register_i = 3'd0; b1.Read_Register_B_i = 3'd0;
      #1;
      checks++; if (b1.Issue_Ready_o !== 1'b1) begin errors++; $display("FAIL s_ready got %b exp 1", b1.Issue_Ready_o); end
      checks++; if (b1.Hazard_B_o !== 1'b0) begin errors++; $display("FAIL s_haz0 got %b exp 0", b1.Hazard_B_o); end
      tick();
      b1.Issue_Valid_i = 1'b0;
      #1;
      checks++; if (b1.Hazard_B_o !== 1'b1) begin errors++; $display("FAIL s_haz1 got %b exp 1", b1.Hazard_B_o); end
      checks++; if (b1.Pending_o !== 8'h01) begin errors++; $display("FAIL s_pend got %h exp 01", b1.Pending_o); end
      checks++; if (b1.Pending_Count_o !== 4'd1) begin errors++; $display("FAIL s_cnt got %0d exp 1", b1.Pending_Count_o); end
      checks++; if (b1.Issue_Ready_o !== 1'b0) begin errors++; $display("FAIL s_stall got %b exp 0", b1.Issue_Ready_o); end
      tick();
      b1.WB_Valid_i = 1'b1; b1.Write_Register_i = 3'd0;
      #1;
      checks++; if (b1.Hazard_B_o !== 1'b0) begin errors++; $display("FAIL s_bypass got %b exp 0", b1.Hazard_B_o); end
      tick();
      b1.Write_Register_i = 3'd3;
      #1;
      checks++; if (b1.CP_o !== 8'h01) begin errors++; $display("FAIL s_cp0 got %h exp 01", b1.CP_o); end
      checks++; if (b1.Pending_o !== 8'h00) begin errors++; $display("FAIL s_pend0 got %h exp 00", b1.Pending_o); end
      checks++; if (b1.Err_o !== 1'b0) begin errors++; $display("FAIL s_err0 got %b exp 0", b1.Err_o); end
      tick();
      b1.WB_Valid_i = 1'b0;
      #1;
      checks++; if (b1.CP_o !== 8'h08) begin errors++; $display("FAIL s_cp3 got %h exp 08", b1.CP_o); end
      checks++; if (b1.Err_o !== 1'b1) begin errors++; $display("FAIL s_err1 got %b exp 1", b1.Err_o); end
      tick();
   endtask

   initial begin
      test_reset();
      test_issue_wb();
      test_waw();
      test_wb_sweep();
      test_reset_mid();
      test_zero_protect();
      test_small_unprotected();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/regfile_wb_scoreboard.md
Name: regfile_wb_scoreboard

Overview:
Parametrised successor to the register-file write-enable decoder.
- Registers the one-hot write-enable vector for the register file.
- Keeps a per-register pending-write scoreboard. A bit is set when an instruction issues with that destination and cleared when that destination writes back.
- Drives read-after-write hazard flags for two source operands, and issue back-pressure on write-after-write conflicts.
- Sits between decode/issue and the register file write port.

Parameters:
ADDR_W, 5, register address width
NUM_REGS, 2**ADDR_W, number of architectural registers; decode width
ZERO_REG_PROTECT, 1, 1 = register 0 is hard-wired: never pending, never write-enabled

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
Issue_Valid_i  in  1  issue request with a destination register
Issue_Register_i  in  ADDR_W  destination of the issuing instruction
Issue_Ready_o  out  1  issue accepted this cycle (combinational)
WB_Valid_i  in  1  writeback occurring this cycle
Write_Register_i  in  ADDR_W  writeback destination
Read_Register_A_i  in  ADDR_W  source operand A
Read_Register_B_i  in  ADDR_W  source operand B
Hazard_A_o  out  1  operand A has an outstanding write (combinational)
Hazard_B_o  out  1  operand B has an outstanding write (combinational)
CP_o  out  NUM_REGS  registered one-hot write enable
Pending_o  out  NUM_REGS  scoreboard state
Pending_Count_o  out  ADDR_W+1  number of set pending bits
Err_o  out  1  sticky: writeback to a non-pending register

Behaviour:
- Reset: synchronous, active-high. On any clock edge with reset=1, the following clear to 0 and any in-flight CP_o pulse is dropped: CP_o, Pending_o, Pending_Count_o, Err_o.
- Decode latency:
  - WB_Valid_i=1 at edge N gives CP_o[Write_Register_i]=1 during cycle N+1, for exactly one cycle.
  - CP_o is all zeros otherwise.
  - Back-to-back writebacks give back-to-back one-hot values with no idle gap.
- Zero register (ZERO_REG_PROTECT=1):
  - A writeback to 0 gives CP_o all zeros.
  - An issue to 0 always has Issue_Ready_o=1 and sets no pending bit.
  - Hazard flags for register 0 are always 0.
  - A writeback to 0 never sets Err_o.
- Zero register (ZERO_REG_PROTECT=0): register 0 is treated like any other register.
- Clear-bypass signal: wbclr[r] = WB_Valid_i and Write_Register_i==r.
- Hazard_X_o = Pending_o[Read_Register_X_i] and not wbclr[Read_Register_X_i]. The value being written this cycle is forwarded, so it is not a hazard.
- Issue_Ready_o = not (Pending_o[Issue_Register_i] and not wbclr[Issue_Register_i]). This is a WAW stall. The output is valid regardless of Issue_Valid_i.
- Accepted issue: Issue_Valid_i and Issue_Ready_o. An issue with ready low is ignored, with no state change.
- Pending update per edge: next[r] = (Pending_o[r] and not wbclr[r]) or (accepted issue to r). When issue and writeback target the same register in the same cycle, set wins, so the bit stays 1.
- Pending_Count_o is registered and equals the popcount of the next pending value. It is updated on the same edge as Pending_o and never exceeds NUM_REGS (or NUM_REGS-1 when protected).
- Err_o: set on the edge after WB_Valid_i to a register whose pending bit is 0, excluding protected register 0. It holds until reset. CP_o is still asserted for such a writeback, and pending is unchanged.
- An out-of-range address cannot occur: NUM_REGS = 2**ADDR_W.

Test Plan:
- Reset then idle → CP_o=0, Pending_o=0, Pending_Count_o=0, Err_o=0, Issue_Ready_o=1.
- Issue reg 5 at cycle 1; WB reg 5 at cycle 4 → Pending_o=0x20 during cycles 2-4, Hazard_A_o=1 for Read_Register_A_i=5 in cycles 2-3, Hazard_A_o=0 in cycle 4 (bypass), CP_o=0x00000020 in cycle 5 only, Pending_Count_o 1→0.
- Reg 7 pending, issue reg 7 without WB → Issue_Ready_o=0, pending unchanged. Issue reg 7 with WB reg 7 in the same cycle → ready=1, Pending_o[7] stays 1, CP_o=0x80 next cycle.
- WB sweep over regs 0..31 on consecutive cycles, ZERO_REG_PROTECT=1 → CP_o is 0 then 1<<1 … 1<<31, one per cycle, and Err_o=1 from the cycle after WB reg 1.
- Issue regs 1, 2, 3, then assert reset mid-sequence with WB reg 2 active → all outputs 0 next cycle, no CP_o pulse, count 0.
- ADDR_W=3, ZERO_REG_PROTECT=0: issue and WB reg 0 → CP_o=0x01, and Hazard_B_o=1 for reg 0 while pending.
